fft_ctrl: RTL and testbench

- Frequency-measurement controller for the 10-bit ADC path.
- On a debounced press of `key`, it calibrates the signal midpoint from min/max, then counts hysteretic rising midpoint crossings of `ad_data` over a fixed gate window.
- Reports the count as `wave_freq`, qualified by `freq_vaild`.
- Sits between the ADC capture logic and the display/measurement-result consumers.

---
 rtl/fft_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_fft_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fft_ctrl.sv
// fft_ctrl: frequency-measurement controller for the 10-bit ADC path.
// A debounced key press starts a min/max calibration of the signal midpoint,
// then counts hysteretic rising midpoint crossings over a fixed gate window.
//
// state | meaning
// IDLE  | waiting for the first key press after reset
// CAL   | tracking min/max of the sample for CAL_CYCLES clocks
// GATE  | counting rising crossings for GATE_CYCLES clocks
// DONE  | result held on wave_freq with freq_vaild high; a press re-measures
//
// Latency: freq_vaild rises CAL_CYCLES+GATE_CYCLES+1 clocks after the edge on
// which start goes high (start -> CAL entry 1 clock, CAL_CYCLES clocks in CAL,
// GATE_CYCLES clocks in GATE, result loaded on the last GATE edge).
module fft_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CAL_CYCLES      = 1_000_000,
    parameter int GATE_CYCLES     = 50_000_000,
    parameter int HYST            = 16
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic [9:0]  ad_data,
    input  logic        key,
    output logic [15:0] wave_freq,
    output logic        freq_vaild
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (CAL_CYCLES > GATE_CYCLES) ? CAL_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] CAL_LOAD  = TMR_W'(CAL_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic signed [11:0] HYST_S  = 12'(HYST);
    localparam logic [10:0] FLAT_SPAN      = 11'(4 * HYST);

    typedef enum logic [1:0] {IDLE, CAL, GATE, DONE} state_t;

    state_t state, state_nxt;

    logic            key_s1, key_s2;
    logic            key_lvl, key_lvl_d;
    logic [DB_W-1:0] db_cnt;
    logic            start;

    logic [9:0]       s;
    logic [9:0]       mn, mx, mid;
    logic [9:0]       mn_nxt, mx_nxt, mid_nxt;
    logic             flat;
    logic [TMR_W-1:0] tmr;
    logic             tmr_tc;

    logic signed [11:0] s_sgn, thr_lo, thr_hi;
    logic               below, above, crossing;
    logic               armed, armed_nxt;
    logic [15:0]        cnt, cnt_nxt;

    // two-flop synchronizer for the asynchronous pushbutton, idles high
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    // accept a new key level only after it has differed for DEBOUNCE_CYCLES clocks in a row
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            key_lvl   <= 1'b1;
            key_lvl_d <= 1'b1;
            db_cnt    <= '0;
        end else begin
            key_lvl_d <= key_lvl;
            if (key_s2 == key_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_lvl <= key_s2;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign start = key_lvl_d & ~key_lvl;

    // single register stage on the ADC sample; every compare uses s
    always_ff @(posedge clk_50m) begin
        if (rst) s <= '0;
        else     s <= ad_data;
    end

    // calibration arithmetic and hysteresis compares (thresholds kept signed so mid-HYST cannot wrap)
    always_comb begin
        mn_nxt    = (s < mn) ? s : mn;
        mx_nxt    = (s > mx) ? s : mx;
        mid_nxt   = 10'(({1'b0, mx_nxt} + {1'b0, mn_nxt}) >> 1);
        flat      = ({1'b0, mx_nxt} - {1'b0, mn_nxt}) < FLAT_SPAN;
        tmr_tc    = (tmr == '0);
        s_sgn     = $signed({2'b00, s});
        thr_lo    = $signed({2'b00, mid}) - HYST_S;
        thr_hi    = $signed({2'b00, mid}) + HYST_S;
        below     = s_sgn < thr_lo;
        above     = s_sgn > thr_hi;
        crossing  = armed & above;
        armed_nxt = armed;
        if (crossing)   armed_nxt = 1'b0;
        else if (below) armed_nxt = 1'b1;
        cnt_nxt   = (crossing && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    end

    // state register
    always_ff @(posedge clk_50m) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state decode; start is ignored in CAL and GATE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CAL;
            CAL:  if (tmr_tc) state_nxt = flat ? DONE : GATE;
            GATE: if (tmr_tc) state_nxt = DONE;
            DONE: if (start) state_nxt = CAL;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: timers, min/max, crossing counter and result registers
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            mn         <= '0;
            mx         <= '0;
            mid        <= '0;
            tmr        <= '0;
            armed      <= 1'b0;
            cnt        <= '0;
            wave_freq  <= '0;
            freq_vaild <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        freq_vaild <= 1'b0;
                        mn         <= 10'h3FF;
                        mx         <= '0;
                        tmr        <= CAL_LOAD;
                    end
                end
                CAL: begin
                    mn <= mn_nxt;
                    mx <= mx_nxt;
                    if (tmr_tc) begin
                        if (flat) begin
                            wave_freq  <= '0;
                            freq_vaild <= 1'b1;
                        end else begin
                            mid   <= mid_nxt;
                            tmr   <= GATE_LOAD;
                            cnt   <= '0;
                            armed <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                GATE: begin
                    armed <= armed_nxt;
                    cnt   <= cnt_nxt;
                    if (tmr_tc) begin
                        wave_freq  <= cnt_nxt;
                        freq_vaild <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: directed bench for fft_ctrl with short debounce/cal/gate windows.
module tb_fft_ctrl;

    localparam int DEB  = 16;
    localparam int CAL  = 2000;
    localparam int GATE = 10000;
    // key pressed just before edge 1: 2 sync + 16 debounce edges -> start on edge 18,
    // CAL entry edge 19, GATE entry edge 19+CAL, result on edge 19+CAL+GATE
    localparam int LAT_MEAS = 19 + CAL + GATE;
    localparam int LAT_FLAT = 19 + CAL;
    localparam int LAT_DROP = 19;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic [9:0]  ad_data;
    logic        key;
    logic [15:0] wave_freq;
    logic        freq_vaild;

    int n_tests = 0;
    int n_fail  = 0;

    int period   = 100;
    bit flat_in  = 1'b0;
    int flat_val = 300;

    fft_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CAL_CYCLES(CAL),
        .GATE_CYCLES(GATE),
        .HYST(16)
    ) dut (
        .clk_50m(clk_50m),
        .rst(rst),
        .ad_data(ad_data),
        .key(key),
        .wave_freq(wave_freq),
        .freq_vaild(freq_vaild)
    );

    always #10 clk_50m = ~clk_50m;

    // ADC stimulus: 512 + 400*sin with selectable period, or a flat level
    initial begin
        int ph;
        int v;
        ph = 0;
        ad_data = 10'd512;
        forever begin
            @(posedge clk_50m);
            #2;
            ph = (ph + 1) % period;
            if (flat_in) v = flat_val;
            else v = 512 + $rtoi(400.0 * $sin(2.0 * 3.14159265358979 * ph / period));
            ad_data = v[9:0];
        end
    end

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        n_tests++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // press key for 200 clocks, optionally a second press at press2_at, stop at rst_at or on valid rise
    task automatic run_meas(input int press2_at, input int rst_at, input int budget,
                            output int lat, output int drop);
        bit low_seen;
        bit prev_hi;
        lat = -1;
        drop = -1;
        low_seen = !freq_vaild;
        prev_hi = freq_vaild;
        key = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk_50m);
            #1;
            if (n == 200) key = 1'b1;
            if (press2_at > 0 && n == press2_at) key = 1'b0;
            if (press2_at > 0 && n == press2_at + 200) key = 1'b1;
            if (prev_hi && !freq_vaild && drop < 0) drop = n;
            if (freq_vaild && low_seen) begin
                lat = n;
                break;
            end
            if (!freq_vaild) low_seen = 1'b1;
            prev_hi = freq_vaild;
            if (rst_at > 0 && n == rst_at) break;
        end
        key = 1'b1;
    endtask

    initial begin
        int lat;
        int drop;
        int hi_cnt;

        rst = 1'b1;
        key = 1'b1;
        repeat (5) @(posedge clk_50m);
        #1;
        check("rst_freq", wave_freq, 0, 0);
        check("rst_vaild", freq_vaild, 0, 0);
        rst = 1'b0;

        hi_cnt = 0;
        repeat (10000) begin
            @(posedge clk_50m);
            #1;
            if (freq_vaild) hi_cnt++;
        end
        check("idle_vaild_hi", hi_cnt, 0, 0);
        check("idle_freq", wave_freq, 0, 0);

        // bounce: any accepted start would give a flat result well inside the wait
        flat_in = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) key = ~key;
            @(posedge clk_50m);
            #1;
        end
        key = 1'b1;
        hi_cnt = 0;
        repeat (3000) begin
            @(posedge clk_50m);
            #1;
            if (freq_vaild) hi_cnt++;
        end
        check("bounce_vaild_hi", hi_cnt, 0, 0);

        flat_in = 1'b0;
        period = 100;
        run_meas(0, 0, LAT_MEAS + 200, lat, drop);
        check("meas1_lat", lat, LAT_MEAS, 0);
        check("meas1_freq", wave_freq, 100, 1);

        flat_in = 1'b1;
        run_meas(0, 0, LAT_FLAT + 200, lat, drop);
        check("flat_drop", drop, LAT_DROP, 0);
        check("flat_lat", lat, LAT_FLAT, 0);
        check("flat_freq", wave_freq, 0, 0);
        check("flat_vaild", freq_vaild, 1, 0);

        flat_in = 1'b0;
        run_meas(5000, 0, LAT_MEAS + 200, lat, drop);
        check("gatepress_lat", lat, LAT_MEAS, 0);
        check("gatepress_freq", wave_freq, 100, 1);

        period = 50;
        run_meas(0, 0, LAT_MEAS + 200, lat, drop);
        check("restart_drop", drop, LAT_DROP, 0);
        check("restart_lat", lat, LAT_MEAS, 0);
        check("restart_freq", wave_freq, 200, 1);

        period = 100;
        run_meas(0, LAT_FLAT + 5000, LAT_MEAS + 200, lat, drop);
        check("rstgate_early_vaild", lat, -1, 0);
        rst = 1'b1;
        @(posedge clk_50m);
        #1;
        check("rstgate_vaild", freq_vaild, 0, 0);
        check("rstgate_freq", wave_freq, 0, 0);
        rst = 1'b0;
        hi_cnt = 0;
        repeat (500) begin
            @(posedge clk_50m);
            #1;
            if (freq_vaild) hi_cnt++;
        end
        check("rstgate_idle_hi", hi_cnt, 0, 0);
        run_meas(0, 0, LAT_MEAS + 200, lat, drop);
        check("after_rst_lat", lat, LAT_MEAS, 0);
        check("after_rst_freq", wave_freq, 100, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
